// File: rtl/lsu_mem_master_if.sv
// Core request/response handshake plus data-memory port of the load/store initiator.
// The master modport is the LSU side; slave is the core/memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MEM_WE;
  logic [31:0] MEM_A;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, MEM_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, MEM_WE, MEM_A, MEM_WD
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, MEM_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, MEM_WE, MEM_A, MEM_WD
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator with lane extract/extend and read-modify-write sub-word stores.
// Optional misalignment trapping is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_mem_master (
  input  logic CLK,
  input  logic RST_N,
  lsu_mem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;
  logic        accept;
  logic        misalign;
  logic        req_ready_c;
  logic        resp_valid_c;

  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  // Replace the addressed lane(s) of the fetched word with right-aligned store data.
  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] m;
    logic [1:0]  li;
    m = base;
    for (int i = 0; i < 4; i++) begin
      li = 2'(i);
      case (sz)
        2'b00:   if (li == a) m[8*i +: 8] = wd[7:0];
        2'b01:   if (li[1] == a[1]) m[8*i +: 8] = li[0] ? wd[15:8] : wd[7:0];
        default: m[8*i +: 8] = wd[8*i +: 8];
      endcase
    end
    return m;
  endfunction

  assign accept = bus.req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign misalign = bus.req_funct3[1] ? (bus.req_addr[1:0] != 2'b00)
                                      : (bus.req_funct3[0] && bus.req_addr[0]);
  assign bus.resp_err = err_q;
`else
  assign misalign     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (misalign)               state_nxt = RESP;
          else if (!bus.req_we)       state_nxt = RD;
          else if (bus.req_funct3[1]) state_nxt = WR;
          else                        state_nxt = RMW_RD;
        end
      end
      RD:     state_nxt = RESP;
      RMW_RD: state_nxt = WR;
      WR:     state_nxt = RESP;
      RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      f3_q     <= '0;
      alo_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        f3_q    <= bus.req_funct3;
        alo_q   <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q   <= misalign;
`endif
        // A trapped access never touches the memory port, so MEM_A/MEM_WD keep their old values.
        if (!misalign) begin
          mem_a_q <= bus.req_addr;
          if (bus.req_we && bus.req_funct3[1]) mem_wd_q <= bus.req_wdata;
        end
      end
      if (state == RD)     rdata_q  <= load_ext(bus.MEM_RD, alo_q, f3_q);
      if (state == RMW_RD) mem_wd_q <= merge(bus.MEM_RD, wdata_q, alo_q, f3_q[1:0]);
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.MEM_A      = mem_a_q;
  assign bus.MEM_WD     = mem_wd_q;
  // Gated with reset so a write in flight is squashed in the same cycle reset asserts.
  assign bus.MEM_WE     = (state == WR) && RST_N;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: word memory model, expected-response queue and a response monitor.
module tb_lsu_mem_master;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [16];
  exp_t        exp_q[$];
  int          n_tot;
  int          n_pass;
  int          we_cnt;

  lsu_mem_master_if bus ();

  lsu_mem_master dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.MEM_RD = mem[bus.MEM_A[5:2]];

  always @(posedge clk) if (bus.MEM_WE) mem[bus.MEM_A[5:2]] <= bus.MEM_WD;

  always @(negedge clk) if (bus.MEM_WE) we_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
      end
    end
  end

  // Issue one request, check accept-to-resp_valid latency and MEM_WE cycles, complete the handshake.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int elat, input int ewe, input string nm);
    int cyc;
    int we0;
    exp_q.push_back('{rdata: er, err: ee});
    @(negedge clk);
    we0 = we_cnt;
    chk({nm, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(elat));
    @(posedge clk); #1;
    chk({nm, "_we_cycles"}, 32'(we_cnt - we0), 32'(ewe));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_tot = 0; n_pass = 0; we_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.MEM_WE}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_a", bus.MEM_A, 32'h0);
    chk("rst_mem_wd", bus.MEM_WD, 32'h0);

    mem[0] = 32'h800000F1;
    run_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h800000F1, 1'b0, 2, 0, "lw0");

    mem[0] = 32'h80FF1234;
    run_req(1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, "lb3");
    run_req(1'b0, 3'b100, 32'h3, 32'h0, 32'h00000080, 1'b0, 2, 0, "lbu3");
    run_req(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0, "lh2");
    run_req(1'b0, 3'b101, 32'h0, 32'h0, 32'h00001234, 1'b0, 2, 0, "lhu0");

    mem[1] = 32'h11223344;
    run_req(1'b1, 3'b000, 32'h5, 32'hABCDEFAB, 32'h0, 1'b0, 3, 1, "sb5");
    chk("sb5_mem", mem[1], 32'h1122AB44);
    run_req(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, "sh6");
    chk("sh6_mem", mem[1], 32'hBEEFAB44);
    run_req(1'b1, 3'b010, 32'hC, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, "swc");
    chk("swc_mem", mem[3], 32'hCAFEF00D);

    mem[0] = 32'h12345678;
    run_req(1'b0, 3'b010, 32'h2, 32'h0, TRAP ? 32'h0 : 32'h12345678, TRAP,
            TRAP ? 1 : 2, 0, "lw_mis");
    run_req(1'b1, 3'b001, 32'h5, 32'h00007777, 32'h0, TRAP, TRAP ? 1 : 3, TRAP ? 0 : 1, "sh_mis");
    chk("sh_mis_mem", mem[1], TRAP ? 32'hBEEFAB44 : 32'hBEEF7777);

    // Reset while the word store sits in WR: write squashed, no response.
    mem[2] = 32'h55AA55AA;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h8;
    bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstwr_we_in_wr", {31'b0, bus.MEM_WE}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rstwr_we_gated", {31'b0, bus.MEM_WE}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstwr_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rstwr_mem2", mem[2], 32'h55AA55AA);
    repeat (2) begin
      @(negedge clk);
      chk("rstwr_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end

    // Backpressure: response held 4 cycles while a second request waits.
    mem[0] = 32'h0BADF00D;
    bus.resp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'h0BADF00D, err: 1'b0});
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_funct3 = 3'b100; bus.req_addr = 32'h1;
    exp_q.push_back('{rdata: 32'h000000F0, err: 1'b0});
    cyc = 1;
    while (!bus.resp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_lat", 32'(cyc), 32'd2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_held", {31'b0, bus.resp_valid}, 32'd1);
      chk("bp_rdata_held", bus.resp_rdata, 32'h0BADF00D);
      chk("bp_no_accept", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_after_hs_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.resp_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp2_lat", 32'(cyc), 32'd2);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
